// File: rtl/uart_pkg.sv
// Shared definitions for the UART receiver: frame-sequencer state encoding,
// legal oversampling ratios and the default frame data width.
package uart_pkg;

    localparam int unsigned BUS_WIDTH_DEF = 8;

    // Oversampling ratios the receiver supports; anything else falls back to 8.
    localparam int unsigned PRESC_8  = 8;
    localparam int unsigned PRESC_16 = 16;
    localparam int unsigned PRESC_32 = 32;

    typedef enum logic [2:0] {
        StIdle,
        StStart,
        StData,
        StParity,
        StStop,
        StErrChk
    } rx_state_e;

    // Maps a requested prescale onto a supported one.
    function automatic int unsigned legal_presc(input int unsigned p);
        if (p == PRESC_16 || p == PRESC_32) begin
            return p;
        end
        return PRESC_8;
    endfunction

endpackage

// File: rtl/uart_rx_edge_bit_cnt.sv
// Oversample edge counter and bit counter for the UART receiver.
// While cnt_en is high, edge_cnt counts 0..presc-1 and wraps; each wrap advances
// bit_cnt. When cnt_en is low both counters are held at zero.
// Ports:
//   CLK      in   oversampling clock
//   RST      in   asynchronous reset, active-low
//   cnt_en   in   count enable; low clears both counters
//   presc    in   latched oversampling ratio
//   edge_cnt out  oversample index within the current bit
//   bit_cnt  out  bit index within the frame
//   bit_end  out  edge_cnt == presc-1 (last oversample of the bit)
module uart_rx_edge_bit_cnt #(
    parameter int unsigned PRESC_W   = 6,
    parameter int unsigned BIT_CNT_W = 4
) (
    input  logic                 CLK,
    input  logic                 RST,
    input  logic                 cnt_en,
    input  logic [PRESC_W-1:0]   presc,
    output logic [PRESC_W-1:0]   edge_cnt,
    output logic [BIT_CNT_W-1:0] bit_cnt,
    output logic                 bit_end
);

    logic [PRESC_W-1:0]   edge_q;
    logic [BIT_CNT_W-1:0] bit_q;

    assign bit_end  = (edge_q == presc - PRESC_W'(1));
    assign edge_cnt = edge_q;
    assign bit_cnt  = bit_q;

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            edge_q <= '0;
            bit_q  <= '0;
        end else if (!cnt_en) begin
            edge_q <= '0;
            bit_q  <= '0;
        end else if (bit_end) begin
            edge_q <= '0;
            bit_q  <= bit_q + BIT_CNT_W'(1);
        end else begin
            edge_q <= edge_q + PRESC_W'(1);
        end
    end

endmodule

// File: rtl/uart_rx_ctrl.sv
// Frame sequencer for the UART receiver. Detects the start edge on RX_IN, runs the
// edge/bit counter through start, data, optional parity and stop bits, enables the
// sampler, checkers and deserializer in turn, and pulses data_valid for clean frames.
// Ports:
//   CLK, RST                  clock; asynchronous active-low reset
//   RX_IN                     synchronized serial input, idle high
//   PAR_EN                    parity bit present (sampled at end of last data bit)
//   Prescale                  oversampling ratio 8/16/32, latched at the start edge
//   strt_glitch/par_err/stp_err  registered checker results
//   dat_samp_en               sampler enable for START..STOP
//   edge_cnt, bit_cnt         counter positions
//   deser_en                  one-cycle shift strobe per data bit
//   strt_chk_en/par_chk_en/stp_chk_en  checker enables, edges [M, P-1] of their bit
//   data_valid                one-cycle pulse for an error-free frame
module uart_rx_ctrl
    import uart_pkg::*;
#(
    parameter int unsigned BUS_WIDTH = BUS_WIDTH_DEF,
    parameter int unsigned PRESC_W   = 6,
    parameter int unsigned BIT_CNT_W = 4
) (
    input  logic                 CLK,
    input  logic                 RST,
    input  logic                 RX_IN,
    input  logic                 PAR_EN,
    input  logic [PRESC_W-1:0]   Prescale,
    input  logic                 strt_glitch,
    input  logic                 par_err,
    input  logic                 stp_err,
    output logic                 dat_samp_en,
    output logic [PRESC_W-1:0]   edge_cnt,
    output logic [BIT_CNT_W-1:0] bit_cnt,
    output logic                 deser_en,
    output logic                 strt_chk_en,
    output logic                 par_chk_en,
    output logic                 stp_chk_en,
    output logic                 data_valid
);

    rx_state_e          state_q, state_d;
    logic [PRESC_W-1:0] presc_q, presc_d;
    logic               par_flag_q, par_flag_d;

    logic dat_samp_en_q, dat_samp_en_d;
    logic deser_en_q, deser_en_d;
    logic strt_chk_en_q, strt_chk_en_d;
    logic par_chk_en_q, par_chk_en_d;
    logic stp_chk_en_q, stp_chk_en_d;
    logic data_valid_q, data_valid_d;

    logic               bit_end;
    logic               run_q, run_d, cnt_en;
    logic [PRESC_W-1:0] mid_m1, last_m1;
    logic               in_win;

    assign run_q = (state_q == StStart) || (state_q == StData) ||
                   (state_q == StParity) || (state_q == StStop);
    assign run_d = (state_d == StStart) || (state_d == StData) ||
                   (state_d == StParity) || (state_d == StStop);

    // Counting only while staying inside the frame: entry and exit both clear the
    // counters, so every frame starts at edge 0 / bit 0 and IDLE/ERR_CHK show zeros.
    assign cnt_en = run_q && run_d;

    uart_rx_edge_bit_cnt #(
        .PRESC_W   (PRESC_W),
        .BIT_CNT_W (BIT_CNT_W)
    ) u_cnt (
        .CLK      (CLK),
        .RST      (RST),
        .cnt_en   (cnt_en),
        .presc    (presc_q),
        .edge_cnt (edge_cnt),
        .bit_cnt  (bit_cnt),
        .bit_end  (bit_end)
    );

    // Outputs are registered, so decode one edge early: the enable window
    // [M, P-1] is entered from edge_cnt in [M-1, P-2] of the same bit.
    assign mid_m1  = (presc_q >> 1) + PRESC_W'(1);
    assign last_m1 = presc_q - PRESC_W'(2);
    assign in_win  = (edge_cnt >= mid_m1) && (edge_cnt <= last_m1);

    always_comb begin
        state_d    = state_q;
        presc_d    = presc_q;
        par_flag_d = par_flag_q;
        case (state_q)
            StIdle: begin
                if (!RX_IN) begin
                    state_d    = StStart;
                    presc_d    = PRESC_W'(legal_presc(32'(Prescale)));
                    par_flag_d = 1'b0;
                end
            end
            StStart: begin
                if (bit_end) begin
                    state_d = strt_glitch ? StIdle : StData;
                end
            end
            StData: begin
                if (bit_end && (bit_cnt == BIT_CNT_W'(BUS_WIDTH))) begin
                    state_d = PAR_EN ? StParity : StStop;
                end
            end
            StParity: begin
                if (bit_end) begin
                    par_flag_d = par_err;
                    state_d    = StStop;
                end
            end
            StStop: begin
                if (bit_end) begin
                    state_d = StErrChk;
                end
            end
            StErrChk: state_d = StIdle;
            default:  state_d = StIdle;
        endcase
    end

    always_comb begin
        dat_samp_en_d = run_d;
        strt_chk_en_d = (state_q == StStart) && in_win;
        deser_en_d    = (state_q == StData) && (edge_cnt == mid_m1);
        par_chk_en_d  = (state_q == StParity) && in_win;
        stp_chk_en_d  = (state_q == StStop) && in_win;
        // stp_err is judged as the stop bit closes; the result lands in ERR_CHK.
        data_valid_d  = (state_q == StStop) && bit_end && !par_flag_q && !stp_err;
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q       <= StIdle;
            presc_q       <= PRESC_W'(PRESC_8);
            par_flag_q    <= 1'b0;
            dat_samp_en_q <= 1'b0;
            deser_en_q    <= 1'b0;
            strt_chk_en_q <= 1'b0;
            par_chk_en_q  <= 1'b0;
            stp_chk_en_q  <= 1'b0;
            data_valid_q  <= 1'b0;
        end else begin
            state_q       <= state_d;
            presc_q       <= presc_d;
            par_flag_q    <= par_flag_d;
            dat_samp_en_q <= dat_samp_en_d;
            deser_en_q    <= deser_en_d;
            strt_chk_en_q <= strt_chk_en_d;
            par_chk_en_q  <= par_chk_en_d;
            stp_chk_en_q  <= stp_chk_en_d;
            data_valid_q  <= data_valid_d;
        end
    end

    assign dat_samp_en = dat_samp_en_q;
    assign deser_en    = deser_en_q;
    assign strt_chk_en = strt_chk_en_q;
    assign par_chk_en  = par_chk_en_q;
    assign stp_chk_en  = stp_chk_en_q;
    assign data_valid  = data_valid_q;

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Bench for uart_rx_ctrl: directed frames plus randomized frames, each cycle
// compared against a frame-timeline model computed from bit/edge arithmetic.
module tb_uart_rx_ctrl;

    localparam int BW = 8;

    logic       CLK = 1'b0;
    logic       RST;
    logic       RX_IN;
    logic       PAR_EN;
    logic [5:0] Prescale;
    logic       strt_glitch, par_err, stp_err;
    logic       dat_samp_en, deser_en, strt_chk_en, par_chk_en, stp_chk_en, data_valid;
    logic [5:0] edge_cnt;
    logic [3:0] bit_cnt;
    logic [15:0] obs;

    int total = 0;
    int bad   = 0;

    uart_rx_ctrl dut (
        .CLK         (CLK),
        .RST         (RST),
        .RX_IN       (RX_IN),
        .PAR_EN      (PAR_EN),
        .Prescale    (Prescale),
        .strt_glitch (strt_glitch),
        .par_err     (par_err),
        .stp_err     (stp_err),
        .dat_samp_en (dat_samp_en),
        .edge_cnt    (edge_cnt),
        .bit_cnt     (bit_cnt),
        .deser_en    (deser_en),
        .strt_chk_en (strt_chk_en),
        .par_chk_en  (par_chk_en),
        .stp_chk_en  (stp_chk_en),
        .data_valid  (data_valid)
    );

    always #5 CLK = ~CLK;

    assign obs = {dat_samp_en, strt_chk_en, deser_en, par_chk_en, stp_chk_en, data_valid,
                  edge_cnt, bit_cnt};

    task automatic chk(input string tag, input logic [31:0] o, input logic [31:0] e);
        total++;
        assert (o === e) else begin
            bad++;
            $error("FAIL %s t=%0t observed=%h expected=%h", tag, $time, o, e);
        end
    endtask

    // Expected outputs n cycles after the frame entered START.
    // Vector: {samp, strt_chk, deser, par_chk, stp_chk, valid, edge[5:0], bit[3:0]}
    function automatic logic [15:0] model(input int p, input bit pe, input bit gl,
                                          input bit perr, input bit serr, input int n);
        int nbits, b, e, m;
        logic [15:0] v;
        nbits = gl ? 1 : BW + 2 + int'(pe);
        b = n / p;
        e = n % p;
        m = p / 2 + 2;
        v = '0;
        if (n < nbits * p) begin
            v[15]   = 1'b1;
            v[14]   = (b == 0) && (e >= m);
            v[13]   = (b >= 1) && (b <= BW) && (e == m);
            v[12]   = pe && (b == BW + 1) && (e >= m);
            v[11]   = !gl && (b == nbits - 1) && (e >= m);
            v[9:4]  = 6'(e);
            v[3:0]  = 4'(b);
        end else if (!gl && n == nbits * p) begin
            v[10] = !perr && !serr;
        end
        return v;
    endfunction

    task automatic run_frame(input int p_in, input bit pe, input logic [7:0] d, input bit gl,
                             input bit perr, input bit serr, input int gap, input int abort_n,
                             output int n_deser, output int dv_n);
        int p, nbits, last, b;
        p     = (p_in == 16) ? 16 : ((p_in == 32) ? 32 : 8);
        nbits = gl ? 1 : BW + 2 + int'(pe);
        last  = gl ? p : nbits * p;
        n_deser = 0;
        dv_n    = -1;
        for (int g = 0; g < gap; g++) begin
            @(posedge CLK); #1;
            chk("idle", 32'(obs), 32'h0);
            RX_IN       = (g == gap - 1) ? 1'b0 : 1'b1;
            Prescale    = (g == gap - 1) ? 6'(p_in) : 6'($urandom_range(0, 63));
            PAR_EN      = pe;
            strt_glitch = 1'b0;
            par_err     = 1'b0;
            stp_err     = 1'b0;
        end
        for (int n = 0; n <= last; n++) begin
            @(posedge CLK); #1;
            chk("frame", 32'(obs), 32'(model(p, pe, gl, perr, serr, n)));
            if (deser_en) n_deser++;
            if (data_valid) dv_n = n;
            b = n / p;
            strt_glitch = gl && (b == 0);
            par_err     = perr && pe && (b == BW + 1);
            stp_err     = serr && !gl && (b == nbits - 1);
            if (n >= nbits * p)       RX_IN = 1'b1;
            else if (b == 0)          RX_IN = gl ? (n >= 2) : 1'b0;
            else if (b <= BW)         RX_IN = d[b-1];
            else if (pe && b == BW+1) RX_IN = (^d) ^ perr;
            else                      RX_IN = !serr;
            if (n == 1) Prescale = 6'($urandom_range(0, 63));
            if (n == abort_n) begin
                RST = 1'b0;
                #1;
                chk("rst_async", 32'(obs), 32'h0);
                @(posedge CLK); #1;
                chk("rst_hold", 32'(obs), 32'h0);
                RX_IN       = 1'b1;
                strt_glitch = 1'b0;
                par_err     = 1'b0;
                stp_err     = 1'b0;
                RST         = 1'b1;
                return;
            end
        end
        strt_glitch = 1'b0;
        par_err     = 1'b0;
        stp_err     = 1'b0;
        RX_IN       = 1'b1;
    endtask

    initial begin
        int nd, dv;
        int p_in, gap;
        bit pe, gl, perr, serr;
        logic [7:0] d;

        RST = 1'b0; RX_IN = 1'b1; PAR_EN = 1'b0; Prescale = 6'd0;
        strt_glitch = 1'b0; par_err = 1'b0; stp_err = 1'b0;
        #2;
        chk("reset", 32'(obs), 32'h0);
        #10;
        RST = 1'b1;

        // P=8, parity, 0xA5
        run_frame(8, 1'b1, 8'hA5, 1'b0, 1'b0, 1'b0, 3, -1, nd, dv);
        chk("t1_deser", 32'(nd), 32'd8);
        chk("t1_dv_cycle", 32'(dv), 32'd88);

        // P=16, no parity, 0x3C
        run_frame(16, 1'b0, 8'h3C, 1'b0, 1'b0, 1'b0, 2, -1, nd, dv);
        chk("t2_deser", 32'(nd), 32'd8);
        chk("t2_dv_cycle", 32'(dv), 32'd160);

        // Start glitch
        run_frame(8, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 2, -1, nd, dv);
        chk("t3_deser", 32'(nd), 32'd0);
        chk("t3_dv", 32'(dv), 32'hFFFF_FFFF);

        // Parity error, then a clean frame clears the sticky flag
        run_frame(8, 1'b1, 8'h5A, 1'b0, 1'b1, 1'b0, 4, -1, nd, dv);
        chk("t4_dv_bad", 32'(dv), 32'hFFFF_FFFF);
        run_frame(8, 1'b1, 8'h81, 1'b0, 1'b0, 1'b0, 8, -1, nd, dv);
        chk("t4_dv_clean", 32'(dv), 32'd88);

        // Stop error, then two frames one bit apart
        run_frame(8, 1'b0, 8'hF0, 1'b0, 1'b0, 1'b1, 2, -1, nd, dv);
        chk("t5_dv_stp", 32'(dv), 32'hFFFF_FFFF);
        run_frame(8, 1'b0, 8'h12, 1'b0, 1'b0, 1'b0, 8, -1, nd, dv);
        chk("t5_dv_a", 32'(dv), 32'd80);
        run_frame(8, 1'b0, 8'h34, 1'b0, 1'b0, 1'b0, 8, -1, nd, dv);
        chk("t5_dv_b", 32'(dv), 32'd80);

        // Reset at data bit 4 with illegal Prescale=13, then a full frame at 13 (runs as 8)
        run_frame(13, 1'b0, 8'h77, 1'b0, 1'b0, 1'b0, 2, 4 * 8 + 3, nd, dv);
        chk("t6_dv_abort", 32'(dv), 32'hFFFF_FFFF);
        run_frame(13, 1'b0, 8'h99, 1'b0, 1'b0, 1'b0, 3, -1, nd, dv);
        chk("t6_dv_p13", 32'(dv), 32'd80);

        // Randomized frames
        for (int i = 0; i < 12; i++) begin
            case ($urandom_range(0, 3))
                0: p_in = 8;
                1: p_in = 16;
                2: p_in = 32;
                default: p_in = int'($urandom_range(0, 63));
            endcase
            pe   = 1'($urandom_range(0, 1));
            d    = 8'($urandom);
            gl   = ($urandom_range(0, 7) == 0);
            perr = ($urandom_range(0, 3) == 0);
            serr = ($urandom_range(0, 3) == 0);
            gap  = int'($urandom_range(1, 10));
            run_frame(p_in, pe, d, gl, perr, serr, gap, -1, nd, dv);
            chk("rnd_deser", 32'(nd), gl ? 32'd0 : 32'd8);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
